// File: rtl/ac97_rx_pkg.sv
// ac97_rx_pkg: shared constants for the AC'97 capture-side sink.
//   - slot 1/2 field positions used to match and extract register reads
//   - PCM sample width (16 bits, or 20 bits when AC97_RX_20BIT_EN is defined)
//   - CR state encoding
// Build option: AC97_RX_20BIT_EN keeps full 20-bit samples in the FIFO.
package ac97_rx_pkg;

    localparam int REG_IDX_HI = 18;   // slot 1: codec register index
    localparam int REG_IDX_LO = 12;
    localparam int REG_DAT_HI = 19;   // slot 2: 16-bit register value
    localparam int REG_DAT_LO = 4;
    localparam int SMP_MSB    = 19;   // slots 3/4: sample MSB

`ifdef AC97_RX_20BIT_EN
    localparam int SMP_W = 20;
`else
    localparam int SMP_W = 16;
`endif
    localparam int PCM_W = 2 * SMP_W;

    typedef logic [PCM_W-1:0] pcm_word_t;

    localparam logic [0:0] CR_IDLE = 1'b0;
    localparam logic [0:0] CR_WAIT = 1'b1;

endpackage

// File: rtl/ac97_rx_sink_if.sv
// ac97_rx_sink_if: PCM capture stream between the sink and the capture DMA.
//   pcm_valid  FIFO not empty          pcm_ready  consumer takes head entry
//   pcm_data   head entry (FWFT)       pcm_level  current FIFO occupancy
// master = sink side, slave = DMA side.
interface ac97_rx_sink_if #(
    parameter int DW = ac97_rx_pkg::PCM_W,
    parameter int LW = 4
) ();
    logic          pcm_valid;
    logic          pcm_ready;
    logic [DW-1:0] pcm_data;
    logic [LW-1:0] pcm_level;

    modport master (output pcm_valid, pcm_data, pcm_level, input pcm_ready);
    modport slave  (input pcm_valid, pcm_data, pcm_level, output pcm_ready);
endinterface

// File: rtl/ac97_rx_fifo.sv
// ac97_rx_fifo: generic first-word-fall-through synchronous FIFO.
//   push/din/full   write side; a push while full is taken only with a pop
//   pop/dout/empty  read side; dout shows the head entry, 0 when empty
//   level           occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module ac97_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr, rd;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ac97_rx_sink.sv
// ac97_rx_sink: consumer of the AC'97 input-frame deframer (sys_clk domain).
// On each new frame (rising next_frame while enabled) it
//   - matches slot 1/2 register-read responses against an outstanding request
//     (cr_req/cr_req_idx -> cr_busy, cr_done, cr_data, cr_timeout)
//   - pushes frames with both PCM slots valid into a FWFT FIFO drained over
//     the pcm interface; drops on full raise sticky ovf (cleared by ovf_clr).
// df_en is enable registered once for the deframer.
// Build option: AC97_RX_20BIT_EN stores full 20-bit samples (pcm_data 40 bits).
module ac97_rx_sink
    import ac97_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CR_TIMEOUT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        df_en,
    input  logic        next_frame,
    input  logic        frame_valid,
    input  logic        addr_valid,
    input  logic [19:0] addr,
    input  logic        data_valid,
    input  logic [19:0] data,
    input  logic        pcmleft_valid,
    input  logic [19:0] pcmleft,
    input  logic        pcmright_valid,
    input  logic [19:0] pcmright,
    input  logic        cr_req,
    input  logic [6:0]  cr_req_idx,
    output logic        cr_busy,
    output logic        cr_done,
    output logic [15:0] cr_data,
    output logic        cr_timeout,
    output logic        ovf,
    input  logic        ovf_clr,
    ac97_rx_sink_if.master pcm
);
    localparam int          LW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  CR_TO = 8'(CR_TIMEOUT);

    logic next_frame_d, fe;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            next_frame_d <= 1'b0;
            df_en        <= 1'b0;
        end else begin
            next_frame_d <= next_frame;
            df_en        <= enable;
        end
    end

    assign fe = next_frame & ~next_frame_d & enable;

    // ---------------- PCM capture ----------------
    logic          push_req, pop, fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    pcm_word_t     sample;

    assign sample   = {pcmleft[SMP_MSB -: SMP_W], pcmright[SMP_MSB -: SMP_W]};
    assign push_req = fe & frame_valid & pcmleft_valid & pcmright_valid;
    assign pop      = ~fifo_empty & pcm.pcm_ready;

    ac97_rx_fifo #(.WIDTH(PCM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push_req),
        .din   (sample),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (pcm.pcm_data),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign pcm.pcm_valid = ~fifo_empty;
    assign pcm.pcm_level = fifo_level;

    // A same-cycle pop makes room, so only an unrelieved full push overflows.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                        ovf <= 1'b0;
        else if (push_req & fifo_full & ~pop)  ovf <= 1'b1;
        else if (ovf_clr)                      ovf <= 1'b0;
    end

    // ---------------- codec register read ----------------
    logic [0:0] cr_state;
    logic [6:0] cr_idx;
    logic [7:0] cr_cnt, cr_cnt_nxt;
    logic       cr_match;

    assign cr_cnt_nxt = cr_cnt + 8'd1;
    assign cr_match   = frame_valid & addr_valid & data_valid &
                        (addr[REG_IDX_HI:REG_IDX_LO] == cr_idx);
    assign cr_busy    = (cr_state == CR_WAIT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cr_state   <= CR_IDLE;
            cr_idx     <= '0;
            cr_cnt     <= '0;
            cr_data    <= '0;
            cr_done    <= 1'b0;
            cr_timeout <= 1'b0;
        end else begin
            cr_done    <= 1'b0;
            cr_timeout <= 1'b0;
            // A new request always (re)starts the wait; any response in the
            // same cycle belongs to the old request and is dropped.
            if (cr_req) begin
                cr_idx   <= cr_req_idx;
                cr_cnt   <= '0;
                cr_state <= CR_WAIT;
            end else if (cr_state == CR_WAIT && fe) begin
                if (cr_match) begin
                    cr_data  <= data[REG_DAT_HI:REG_DAT_LO];
                    cr_done  <= 1'b1;
                    cr_state <= CR_IDLE;
                end else begin
                    cr_cnt <= cr_cnt_nxt;
                    if (cr_cnt_nxt == CR_TO) begin
                        cr_timeout <= 1'b1;
                        cr_state   <= CR_IDLE;
                    end
                end
            end
        end
    end

    // Slot bits outside the used fields are intentionally ignored.
    logic unused_bits;
`ifdef AC97_RX_20BIT_EN
    assign unused_bits = ^{addr[19], addr[11:0], data[3:0]};
`else
    assign unused_bits = ^{addr[19], addr[11:0], data[3:0], pcmleft[3:0], pcmright[3:0]};
`endif
endmodule

// File: tb/tb_ac97_rx_sink.sv
// tb_ac97_rx_sink: directed self-checking bench for ac97_rx_sink.
// Covers reset, PCM capture/discard, overflow and clear, full+pop, register
// read match/mismatch/restart, timeout, next_frame edge detect, enable gating,
// and asynchronous reset mid-operation.
module tb_ac97_rx_sink;
    import ac97_rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        enable, df_en, next_frame;
    logic        frame_valid, addr_valid, data_valid, pcmleft_valid, pcmright_valid;
    logic [19:0] addr, data, pcmleft, pcmright;
    logic        cr_req, cr_busy, cr_done, cr_timeout, ovf, ovf_clr;
    logic [6:0]  cr_req_idx;
    logic [15:0] cr_data;

    int checks = 0;
    int errors = 0;

    ac97_rx_sink_if #(.DW(PCM_W), .LW(LW)) pcm_if ();

    ac97_rx_sink #(.FIFO_DEPTH(DEPTH), .CR_TIMEOUT(16)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .enable         (enable),
        .df_en          (df_en),
        .next_frame     (next_frame),
        .frame_valid    (frame_valid),
        .addr_valid     (addr_valid),
        .addr           (addr),
        .data_valid     (data_valid),
        .data           (data),
        .pcmleft_valid  (pcmleft_valid),
        .pcmleft        (pcmleft),
        .pcmright_valid (pcmright_valid),
        .pcmright       (pcmright),
        .cr_req         (cr_req),
        .cr_req_idx     (cr_req_idx),
        .cr_busy        (cr_busy),
        .cr_done        (cr_done),
        .cr_data        (cr_data),
        .cr_timeout     (cr_timeout),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr),
        .pcm            (pcm_if.master)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Expected FIFO word for a sample pair.
    function automatic logic [63:0] exp_pcm(input logic [19:0] l, input logic [19:0] r);
`ifdef AC97_RX_20BIT_EN
        return 64'({l, r});
`else
        return 64'({l[19:4], r[19:4]});
`endif
    endfunction

    // One gap cycle with next_frame low, then a single-cycle next_frame.
    // Results of the frame are visible when the task returns.
    task automatic frame(input logic fv, input logic av, input logic [19:0] a,
                         input logic dv, input logic [19:0] d,
                         input logic lv, input logic [19:0] l,
                         input logic rv, input logic [19:0] r, input logic rdy);
        next_frame = 1'b0;
        tick();
        frame_valid = fv; addr_valid = av; addr = a; data_valid = dv; data = d;
        pcmleft_valid = lv; pcmleft = l; pcmright_valid = rv; pcmright = r;
        pcm_if.pcm_ready = rdy;
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        pcm_if.pcm_ready = 1'b0;
    endtask

    task automatic pcm_frame(input logic [19:0] l, input logic [19:0] r, input logic rdy);
        frame(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 1'b1, l, 1'b1, r, rdy);
    endtask

    task automatic reg_frame(input logic av, input logic [19:0] a, input logic [19:0] d);
        frame(1'b1, av, a, 1'b1, d, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
    endtask

    initial begin
        logic [19:0] sl [DEPTH+1];
        logic [19:0] sr [DEPTH+1];

        sys_rst_n = 1'b0; enable = 1'b0; next_frame = 1'b0;
        frame_valid = 1'b0; addr_valid = 1'b0; data_valid = 1'b0;
        pcmleft_valid = 1'b0; pcmright_valid = 1'b0;
        addr = '0; data = '0; pcmleft = '0; pcmright = '0;
        cr_req = 1'b0; cr_req_idx = '0; ovf_clr = 1'b0; pcm_if.pcm_ready = 1'b0;

        #2;
        chk("rst_valid", 64'(pcm_if.pcm_valid), 64'd0);
        chk("rst_level", 64'(pcm_if.pcm_level), 64'd0);
        chk("rst_data",  64'(pcm_if.pcm_data),  64'd0);
        chk("rst_busy",  64'(cr_busy), 64'd0);
        chk("rst_ovf",   64'(ovf), 64'd0);
        chk("rst_df_en", 64'(df_en), 64'd0);
        chk("rst_crdat", 64'(cr_data), 64'd0);

        tick(); tick();
        sys_rst_n = 1'b1;
        enable = 1'b1;
        tick();
        chk("df_en", 64'(df_en), 64'd1);

        // PCM capture
        pcm_frame(20'hABCDE, 20'h12345, 1'b0);
        chk("pcm_valid", 64'(pcm_if.pcm_valid), 64'd1);
`ifdef AC97_RX_20BIT_EN
        chk("pcm_data", 64'(pcm_if.pcm_data), 64'hAB_CDE1_2345);
`else
        chk("pcm_data", 64'(pcm_if.pcm_data), 64'hABCD_1234);
`endif
        chk("pcm_level1", 64'(pcm_if.pcm_level), 64'd1);
        frame(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 20'h11111, 1'b0, 20'h22222, 1'b0);
        chk("one_chan_drop", 64'(pcm_if.pcm_level), 64'd1);
        frame(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b1, 20'h11111, 1'b1, 20'h22222, 1'b0);
        chk("fv0_drop", 64'(pcm_if.pcm_level), 64'd1);

        pcm_if.pcm_ready = 1'b1; tick(); pcm_if.pcm_ready = 1'b0;
        chk("drain1", 64'(pcm_if.pcm_level), 64'd0);

        // Overflow: DEPTH+1 pushes, last one dropped
        for (int i = 0; i <= DEPTH; i++) begin
            sl[i] = 20'h10000 * 20'(i + 1);
            sr[i] = 20'h0AB00 + 20'(i << 8);
            pcm_frame(sl[i], sr[i], 1'b0);
        end
        chk("ovf_level", 64'(pcm_if.pcm_level), 64'd8);
        chk("ovf_set",   64'(ovf), 64'd1);
        chk("ovf_head",  64'(pcm_if.pcm_data), exp_pcm(20'h10000, 20'h0AB00));
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);
        pcm_frame(20'hFFFF0, 20'hEEEE0, 1'b1);
        chk("fullpop_level", 64'(pcm_if.pcm_level), 64'd8);
        chk("fullpop_ovf",   64'(ovf), 64'd0);
        chk("fullpop_head",  64'(pcm_if.pcm_data), exp_pcm(20'h20000, 20'h0AC00));

        pcm_if.pcm_ready = 1'b1;
        repeat (DEPTH) tick();
        chk("drain_all", 64'(pcm_if.pcm_level), 64'd0);
        chk("empty_valid", 64'(pcm_if.pcm_valid), 64'd0);
        tick();
        pcm_if.pcm_ready = 1'b0;
        chk("empty_pop_ignored", 64'(pcm_if.pcm_level), 64'd0);

        // Register read: mismatch then match
        cr_req = 1'b1; cr_req_idx = 7'h26; tick(); cr_req = 1'b0;
        chk("cr_busy_req", 64'(cr_busy), 64'd1);
        reg_frame(1'b1, 20'h02000, 20'h11110);
        chk("cr_busy_miss", 64'(cr_busy), 64'd1);
        chk("cr_done_miss", 64'(cr_done), 64'd0);
        reg_frame(1'b1, 20'h26000, 20'h5A5A0);
        chk("cr_done", 64'(cr_done), 64'd1);
        chk("cr_data", 64'(cr_data), 64'h5A5A);
        chk("cr_idle", 64'(cr_busy), 64'd0);
        tick();
        chk("cr_done_pulse", 64'(cr_done), 64'd0);

        // Restart: a response for the old index in the restart cycle is dropped
        cr_req = 1'b1; cr_req_idx = 7'h10; tick();
        cr_req_idx = 7'h11;
        frame(1'b1, 1'b1, 20'h10000, 1'b1, 20'h12340, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
        cr_req = 1'b0;
        chk("restart_busy", 64'(cr_busy), 64'd1);
        chk("restart_nodone", 64'(cr_done), 64'd0);
        reg_frame(1'b1, 20'h11000, 20'hBEEF0);
        chk("restart_done", 64'(cr_done), 64'd1);
        chk("restart_data", 64'(cr_data), 64'hBEEF);

        // Timeout after 16 frames without a response
        cr_req = 1'b1; cr_req_idx = 7'h05; tick(); cr_req = 1'b0;
        for (int i = 0; i < 15; i++) reg_frame(1'b0, 20'h05000, 20'h0);
        chk("to_busy15", 64'(cr_busy), 64'd1);
        chk("to_early", 64'(cr_timeout), 64'd0);
        reg_frame(1'b0, 20'h05000, 20'h0);
        chk("timeout", 64'(cr_timeout), 64'd1);
        chk("to_idle", 64'(cr_busy), 64'd0);
        chk("to_nodone", 64'(cr_done), 64'd0);
        chk("to_data_held", 64'(cr_data), 64'hBEEF);
        tick();
        chk("to_pulse", 64'(cr_timeout), 64'd0);

        // next_frame held 3 cycles -> one push
        frame_valid = 1'b1; pcmleft_valid = 1'b1; pcmright_valid = 1'b1;
        pcmleft = 20'h33330; pcmright = 20'h44440;
        next_frame = 1'b1; repeat (3) tick(); next_frame = 1'b0; tick();
        chk("nf_held_one", 64'(pcm_if.pcm_level), 64'd1);

        // enable low: no push, FIFO still drains
        enable = 1'b0;
        pcm_frame(20'h55550, 20'h66660, 1'b0);
        chk("dis_nopush", 64'(pcm_if.pcm_level), 64'd1);
        pcm_if.pcm_ready = 1'b1; tick(); pcm_if.pcm_ready = 1'b0;
        chk("dis_drain", 64'(pcm_if.pcm_level), 64'd0);
        enable = 1'b1;
        tick();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) pcm_frame(20'h77770, 20'h88880, 1'b0);
        cr_req = 1'b1; cr_req_idx = 7'h01; tick(); cr_req = 1'b0;
        chk("pre_rst_level", 64'(pcm_if.pcm_level), 64'd3);
        chk("pre_rst_busy", 64'(cr_busy), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(pcm_if.pcm_valid), 64'd0);
        chk("arst_level", 64'(pcm_if.pcm_level), 64'd0);
        chk("arst_busy",  64'(cr_busy), 64'd0);
        chk("arst_ovf",   64'(ovf), 64'd0);
        #10 sys_rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
